rr_mux41_arbiter: RTL and testbench
===================================

Name: rr_mux41_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-1, 4-bit multiplexer datapath between four requesters (a, b, c, d).
- Generates the mux select `s` and a one-hot grant, then presents the selected word downstream with a valid/ready handshake.
- Sits in front of the existing 4:1 mux block; may instantiate it or implement the equivalent select internally.
- Each grant holds for up to BURST accepted beats before rotating priority.

Parameters:
- WIDTH, 4, data width of each requester word and of y_data.
- BURST, 2, max accepted beats per grant; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per source; bit0=a, bit1=b, bit2=c, bit3=d.
- a  input  WIDTH  requester 0 data.
- b  input  WIDTH  requester 1 data.
- c  input  WIDTH  requester 2 data.
- d  input  WIDTH  requester 3 data.
- y_ready  input  1  downstream accepts the word this cycle.
- s  output  2  registered mux select (00=a, 01=b, 10=c, 11=d).
- gnt  output  4  registered one-hot grant, equal to 1<<s while granted, else 0.
- y_data  output  WIDTH  selected word; 0 when y_valid=0.
- y_valid  output  1  word on y_data is offered.
- busy  output  1  FSM in GRANT.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state (immediate on rst_n low, even mid-burst):
  - state=IDLE, s=00, gnt=0000, ptr=00, beat_cnt=0.
  - y_valid=0, y_data=0, busy=0.
  - Any offered beat is discarded; nothing is held over.
- Internal registers:
  - ptr (2b): highest-priority index.
  - beat_cnt (4b).
  - state: IDLE / GRANT.
- IDLE:
  - If req==0, stay.
  - Else pick the first set bit scanning ptr, ptr+1, ... modulo 4.
  - Next edge: s=winner, gnt=1<<winner, beat_cnt=0, state=GRANT.
- GRANT:
  - Combinational outputs: y_valid = req[s]; y_data = selected input when y_valid else 0; busy=1.
  - Transfer occurs when y_valid && y_ready.
  - On transfer with beat_cnt==BURST-1 -> release.
  - On transfer otherwise -> beat_cnt+1, stay in GRANT.
  - If req[s]==0 (requester withdrew) -> release at that edge, whatever the value of y_ready.
  - If y_valid && !y_ready -> hold s, gnt and beat_cnt (stall, no timeout). The requester must hold its data stable while stalled.
- Release: next edge state=IDLE, gnt=0000, ptr=s+1 (mod 4, wraps 3->0), beat_cnt=0. s keeps its last value.
- Latency:
  - req rise in IDLE -> y_valid at the cycle after the next edge (1-cycle grant latency).
  - Release -> new grant: one mandatory IDLE cycle, so a re-grant needs 2 edges after the last beat.
- Requests from other sources during GRANT are ignored until release; there is no preemption.
- Requests that change in the same cycle as arbitration are sampled at that edge only.
- A single requester that is continuously asserting gets BURST beats, then 1 idle cycle, then is re-granted if it is still alone.
- beat_cnt never exceeds BURST-1. BURST=1 gives strict per-beat round robin.

Test Plan:
- Reset mid-burst: grant b, 1 beat accepted, pull rst_n low between edges -> gnt=0000, y_valid=0, s=00 immediately. After release, req=0001 -> a granted first (ptr=0).
- Single requester, y_ready=1, BURST=2, req=0100, c=4'b1100:
  - y_valid high for 2 cycles with y_data=1100 and s=10.
  - Then 1 cycle with gnt=0000.
  - Then re-grant to c.
- All four requesting, y_ready=1, a=1111, b=1110, c=1100, d=1000, BURST=1:
  - Grant order a,b,c,d,a.
  - Output sequence 1111,1110,1100,1000,1111, each separated by one idle cycle.
  - ptr wraps 3->0.
- Stall: grant d=4'b0011, y_ready=0 for 5 cycles -> s=11, gnt=1000, y_valid=1, y_data=0011 stable. Then y_ready=1 -> beat counted (beat_cnt=1).
- Withdrawal: grant a, drop req[0] before any transfer while req[1]=1 -> release next edge, ptr=01, b granted 2 edges later.
- Priority rotation: last grant c (ptr=11), then req=0101 -> a wins, since the scan order is d,a,b,c.

Source files
------------

// File: rtl/rr_mux41_arbiter.sv
// Round-robin arbiter in front of a shared 4:1 WIDTH-bit mux. Grants are held for up
// to BURST accepted beats, then priority rotates to the source after the last owner.
module rr_mux41_arbiter #(
    parameter int WIDTH = 4,
    parameter int BURST = 2   // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             y_ready,
    output logic [1:0]       s,
    output logic [3:0]       gnt,
    output logic [WIDTH-1:0] y_data,
    output logic             y_valid,
    output logic             busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_reg, state_next;
    logic [1:0] s_reg, s_next;
    logic [1:0] ptr_reg, ptr_next;
    logic [3:0] gnt_reg, gnt_next;
    logic [3:0] beat_cnt_reg, beat_cnt_next;

    logic [WIDTH-1:0] src [4];
    logic [3:0]       rot_req;
    logic [1:0]       offset;
    logic [1:0]       winner;
    logic             xfer;
    logic             beat_last;

    assign src[0] = a;
    assign src[1] = b;
    assign src[2] = c;
    assign src[3] = d;

    // Rotate requests so bit 0 is the current highest-priority source; the 2-bit
    // index sum wraps modulo 4 on its own.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_req[gi] = req[ptr_reg + 2'(gi)];
        end
    endgenerate

    always_comb begin
        offset = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) offset = 2'(i);
        end
    end

    assign winner    = ptr_reg + offset;
    assign xfer      = y_valid && y_ready;
    assign beat_last = (beat_cnt_reg == 4'(BURST - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            s_reg        <= 2'd0;
            ptr_reg      <= 2'd0;
            gnt_reg      <= 4'd0;
            beat_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            s_reg        <= s_next;
            ptr_reg      <= ptr_next;
            gnt_reg      <= gnt_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next    = state_reg;
        s_next        = s_reg;
        ptr_next      = ptr_reg;
        gnt_next      = gnt_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next    = GRANT;
                    s_next        = winner;
                    gnt_next      = 4'b0001 << winner;
                    beat_cnt_next = 4'd0;
                end
            end
            GRANT: begin
                // A withdrawn request releases regardless of y_ready; s keeps its value.
                if (!req[s_reg] || (xfer && beat_last)) begin
                    state_next    = IDLE;
                    gnt_next      = 4'd0;
                    ptr_next      = s_reg + 2'd1;
                    beat_cnt_next = 4'd0;
                end else if (xfer) begin
                    beat_cnt_next = beat_cnt_reg + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy    = 1'b0;
        y_valid = 1'b0;
        y_data  = '0;
        if (state_reg == GRANT) begin
            busy    = 1'b1;
            y_valid = req[s_reg];
            if (req[s_reg]) y_data = src[s_reg];
        end
    end

    assign s   = s_reg;
    assign gnt = gnt_reg;

endmodule

// File: tb/tb_rr_mux41_arbiter.sv
// Bench for rr_mux41_arbiter: two instances (BURST=2 and BURST=1) share stimulus and
// are checked every cycle against an owner/beat-count reference model.
module tb_rr_mux41_arbiter;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req;
    logic [WIDTH-1:0] a, b, c, d;
    logic             y_ready;

    logic [1:0]       s_o     [2];
    logic [3:0]       gnt_o   [2];
    logic [WIDTH-1:0] y_data_o[2];
    logic             y_valid_o[2];
    logic             busy_o  [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: owner = -1 when nobody holds the mux.
    int burst  [2] = '{2, 1};
    int owner  [2];
    int beats  [2];
    int ptr    [2];
    int last_s [2];

    always #5 clk = ~clk;

    rr_mux41_arbiter #(.WIDTH(WIDTH), .BURST(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
        .y_ready(y_ready), .s(s_o[0]), .gnt(gnt_o[0]), .y_data(y_data_o[0]),
        .y_valid(y_valid_o[0]), .busy(busy_o[0])
    );

    rr_mux41_arbiter #(.WIDTH(WIDTH), .BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
        .y_ready(y_ready), .s(s_o[1]), .gnt(gnt_o[1]), .y_data(y_data_o[1]),
        .y_valid(y_valid_o[1]), .busy(busy_o[1])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k]  = -1;
            beats[k]  = 0;
            ptr[k]    = 0;
            last_s[k] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit found;
        int idx;
        for (int k = 0; k < 2; k++) begin
            if (owner[k] < 0) begin
                found = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    idx = (ptr[k] + j) % 4;
                    if (!found && req[idx]) begin
                        found     = 1'b1;
                        owner[k]  = idx;
                        last_s[k] = idx;
                        beats[k]  = 0;
                    end
                end
            end else begin
                if (y_ready && req[owner[k]]) beats[k]++;
                if (!req[owner[k]] || beats[k] == burst[k]) begin
                    ptr[k]   = (owner[k] + 1) % 4;
                    owner[k] = -1;
                    beats[k] = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [WIDTH-1:0] words [4];
        logic             e_busy, e_valid;
        logic [3:0]       e_gnt;
        logic [WIDTH-1:0] e_data;
        words = '{a, b, c, d};
        for (int k = 0; k < 2; k++) begin
            e_busy  = (owner[k] >= 0);
            e_gnt   = e_busy ? (4'b0001 << owner[k]) : 4'b0000;
            e_valid = e_busy && req[owner[k]];
            e_data  = e_valid ? words[owner[k]] : '0;
            chk($sformatf("%s.b%0d.s", tag, burst[k]),     8'(s_o[k]),       8'(last_s[k]));
            chk($sformatf("%s.b%0d.gnt", tag, burst[k]),   8'(gnt_o[k]),     8'(e_gnt));
            chk($sformatf("%s.b%0d.valid", tag, burst[k]), 8'(y_valid_o[k]), 8'(e_valid));
            chk($sformatf("%s.b%0d.data", tag, burst[k]),  8'(y_data_o[k]),  8'(e_data));
            chk($sformatf("%s.b%0d.busy", tag, burst[k]),  8'(busy_o[k]),    8'(e_busy));
        end
    endtask

    task automatic step(input logic [3:0] r, input logic rdy, input string tag);
        @(negedge clk);
        req     = r;
        y_ready = rdy;
        #1;
        check_all(tag);
        model_edge();
    endtask

    // Reset pulse placed between edges; outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        chk({tag, ".gnt_now"}, 8'(gnt_o[0]), 8'h00);
        req     = 4'b0000;
        y_ready = 1'b0;
        #1;
        rst_n = 1'b1;
        model_edge();
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0; y_ready = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        model_reset();
        @(negedge clk);
        #1;
        check_all("por");
        rst_n = 1'b1;

        // Reset in the middle of a burst to b, then a must win first (ptr back to 0).
        b = 4'b0101;
        step(4'b0010, 1'b1, "midrst_req");
        step(4'b0010, 1'b1, "midrst_beat");
        step(4'b0010, 1'b0, "midrst_hold");
        do_reset("midrst");
        a = 4'b1010;
        for (int i = 0; i < 3; i++) step(4'b0011, 1'b1, "after_rst");
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, "drain");

        // Lone requester c: BURST beats, one idle cycle, re-grant.
        c = 4'b1100;
        for (int i = 0; i < 10; i++) step(4'b0100, 1'b1, "single_c");

        // All four requesting: grant order rotates and ptr wraps 3->0.
        a = 4'b1111; b = 4'b1110; c = 4'b1100; d = 4'b1000;
        for (int i = 0; i < 16; i++) step(4'b1111, 1'b1, "all4");
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, "drain");

        // Stall on d for five cycles, then accept.
        d = 4'b0011;
        step(4'b1000, 1'b0, "stall_req");
        for (int i = 0; i < 5; i++) step(4'b1000, 1'b0, "stall");
        for (int i = 0; i < 4; i++) step(4'b1000, 1'b1, "stall_go");
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, "drain");

        // Withdrawal: a granted, drops before any transfer while b waits.
        do_reset("wd_rst");
        step(4'b0011, 1'b0, "wd_req");
        step(4'b0011, 1'b0, "wd_granted");
        for (int i = 0; i < 4; i++) step(4'b0010, 1'b1, "wd_drop");

        // Rotation after a grant to c: d,a,b,c scan order lets a beat c.
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, "drain");
        step(4'b0100, 1'b1, "rot_c");
        for (int i = 0; i < 3; i++) step(4'b0100, 1'b1, "rot_c_run");
        step(4'b0000, 1'b1, "rot_gap");
        for (int i = 0; i < 4; i++) step(4'b0101, 1'b1, "rot_ac");

        // Randomized traffic with held request patterns and occasional reset.
        begin
            logic [3:0] r_hold;
            int         hold_left;
            r_hold    = 4'b0;
            hold_left = 0;
            for (int i = 0; i < 500; i++) begin
                if (hold_left == 0) begin
                    r_hold    = 4'($urandom_range(0, 15));
                    hold_left = int'($urandom_range(1, 6));
                end
                hold_left--;
                a = WIDTH'($urandom); b = WIDTH'($urandom);
                c = WIDTH'($urandom); d = WIDTH'($urandom);
                if ($urandom_range(0, 79) == 0) do_reset("rnd_rst");
                else step(r_hold, ($urandom_range(0, 3) != 0), "rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
